// File: rtl/fsk_symbol_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fsk_symbol_sequencer
// Brief    : Turns bytes into a binary-FSK phase-increment sequence for an
//            NCO. It also generates the NCO clk_en strobe. The optional
//            FSK_FRAMING_EN macro adds UART-style start/stop symbols.
// Revision : 1.0 - initial release
// ============================================================================
module fsk_symbol_sequencer #(
   parameter int unsigned PRESCALE     = 4,
   parameter int unsigned SYMBOL_TICKS = 8,
   parameter logic [7:0]  MARK_INC     = 8'd20,
   parameter logic [7:0]  SPACE_INC    = 8'd12
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       clk_en,
   output logic [7:0] phase_increment,
   output logic       busy,
   output logic       bit_out
);

   localparam int unsigned c_pre_w  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned c_tick_w = (SYMBOL_TICKS > 1) ? $clog2(SYMBOL_TICKS) : 1;
`ifdef FSK_FRAMING_EN
   localparam int unsigned c_nsym = 10;
`else
   localparam int unsigned c_nsym = 8;
`endif
   localparam logic [c_pre_w-1:0]  c_pre_last  = c_pre_w'(PRESCALE - 1);
   localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(SYMBOL_TICKS - 1);
   localparam logic [3:0]          c_sym_last  = 4'(c_nsym - 1);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_arm  = 2'd1;
   localparam logic [1:0] c_st_send = 2'd2;

   logic [c_pre_w-1:0]  r_prescaler;
   logic                r_clk_en;
   logic [1:0]          r_state;
   logic [1:0]          w_state_next;
   logic [c_tick_w-1:0] r_tick;
   logic [3:0]          r_bit_idx;
   logic [c_nsym-1:0]   r_shift;
   logic [c_nsym-1:0]   w_frame;
   logic [7:0]          r_phase_inc;
   logic                r_bit;
   logic                w_sym_done;
   logic                w_last_sym;

   function automatic logic [7:0] sym_inc(input logic b);
      return b ? MARK_INC : SPACE_INC;
   endfunction

`ifdef FSK_FRAMING_EN
   assign w_frame = {1'b1, data_in, 1'b0};
`else
   assign w_frame = data_in;
`endif

   assign w_sym_done = r_clk_en && (r_tick == c_tick_last);
   assign w_last_sym = (r_bit_idx == c_sym_last);

   // Free-running prescaler; the strobe is registered off its terminal count.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_prescaler <= '0;
         r_clk_en    <= 1'b0;
      end else begin
         r_clk_en <= (r_prescaler == c_pre_last);
         if (r_prescaler == c_pre_last)
            r_prescaler <= '0;
         else
            r_prescaler <= r_prescaler + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset)
         r_state <= c_st_idle;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle: if (data_valid)              w_state_next = c_st_arm;
         c_st_arm:  if (r_clk_en)                w_state_next = c_st_send;
         c_st_send: if (w_sym_done && w_last_sym) w_state_next = c_st_idle;
         default:                                w_state_next = c_st_idle;
      endcase
   end

   // Symbol datapath: all timing advances only on strobe edges.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_tick      <= '0;
         r_bit_idx   <= 4'd0;
         r_shift     <= '0;
         r_phase_inc <= MARK_INC;
         r_bit       <= 1'b1;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (data_valid) begin
                  r_shift   <= w_frame;
                  r_bit_idx <= 4'd0;
               end
            end
            c_st_arm: begin
               if (r_clk_en) begin
                  r_phase_inc <= sym_inc(r_shift[0]);
                  r_bit       <= r_shift[0];
                  r_tick      <= '0;
               end
            end
            c_st_send: begin
               if (r_clk_en) begin
                  if (r_tick != c_tick_last) begin
                     r_tick <= r_tick + 1'b1;
                  end else begin
                     r_tick <= '0;
                     if (w_last_sym) begin
                        r_phase_inc <= MARK_INC;
                        r_bit       <= 1'b1;
                     end else begin
                        r_bit_idx   <= r_bit_idx + 4'd1;
                        r_shift     <= r_shift >> 1;
                        r_phase_inc <= sym_inc(r_shift[1]);
                        r_bit       <= r_shift[1];
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      data_ready      = (r_state == c_st_idle);
      busy            = (r_state != c_st_idle);
      clk_en          = r_clk_en;
      phase_increment = r_phase_inc;
      bit_out         = r_bit;
   end

endmodule
`default_nettype wire

// File: tb/tb_fsk_symbol_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsk_symbol_sequencer
// Brief    : Directed self-checking bench for fsk_symbol_sequencer, with a
//            default instance and a PRESCALE=1/SYMBOL_TICKS=1 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsk_symbol_sequencer;

   localparam int c_p       = 4;
   localparam int c_st      = 8;
   localparam int c_sym_clk = c_p * c_st;

   logic       clock = 1'b0;
   logic       reset, data_valid;
   logic [7:0] data_in;
   logic       data_ready, clk_en, busy, bit_out;
   logic [7:0] phase_increment;

   logic       reset1, valid1;
   logic [7:0] din1;
   logic       ready1, clk_en1, busy1, bit1;
   logic [7:0] pi1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   fsk_symbol_sequencer dut (
      .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .data_ready(data_ready), .clk_en(clk_en), .phase_increment(phase_increment),
      .busy(busy), .bit_out(bit_out)
   );

   fsk_symbol_sequencer #(.PRESCALE(1), .SYMBOL_TICKS(1)) dut1 (
      .clock(clock), .reset(reset1), .data_in(din1), .data_valid(valid1),
      .data_ready(ready1), .clk_en(clk_en1), .phase_increment(pi1),
      .busy(busy1), .bit_out(bit1)
   );

   task automatic frame_of(input logic [7:0] b, output logic [9:0] bits, output int n);
`ifdef FSK_FRAMING_EN
      bits = {1'b1, b, 1'b0};
      n    = 10;
`else
      bits = {2'b00, b};
      n    = 8;
`endif
   endtask

   task automatic test_reset;
      reset = 1'b1; data_valid = 1'b0; data_in = 8'h00;
      reset1 = 1'b1; valid1 = 1'b0; din1 = 8'h00;
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_cmp++; if (phase_increment !== 8'd20) begin n_bad++; $display("FAIL reset_pi got %0d want 20", phase_increment); end
      n_cmp++; if (data_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", data_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (bit_out !== 1'b1) begin n_bad++; $display("FAIL reset_bit got %b want 1", bit_out); end
      n_cmp++; if (clk_en !== 1'b0) begin n_bad++; $display("FAIL reset_clk_en got %b want 0", clk_en); end
      reset = 1'b0; reset1 = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         n_cmp++;
         if (clk_en !== ((k % 4) == 0)) begin
            n_bad++; $display("FAIL prescale_cycle%0d clk_en got %b want %b", k, clk_en, (k % 4) == 0);
         end
      end
      n_cmp++; if (phase_increment !== 8'd20) begin n_bad++; $display("FAIL idle_pi got %0d want 20", phase_increment); end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic accept_byte(input logic [7:0] b, input bit hold);
      int t = 0;
      while (data_ready !== 1'b1 && t < 2000) begin @(negedge clock); t++; end
      if (data_ready !== 1'b1) begin
         n_cmp++; n_bad++; $display("FAIL accept_timeout ready got %b want 1", data_ready);
      end
      data_in = b; data_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      if (!hold) data_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || data_ready !== 1'b0) begin
         n_bad++; $display("FAIL accept_%h busy/ready got %b/%b want 1/0", b, busy, data_ready);
      end
   endtask

   // Starting in ARM: waits for alignment, then checks every clock of every symbol.
   task automatic check_frame(input logic [7:0] b, input string name);
      logic [9:0] bits;
      int n, t, good;
      logic [7:0] expv, seen;
      frame_of(b, bits, n);
      n_cmp++;
      if (phase_increment !== 8'd20) begin n_bad++; $display("FAIL %s_arm_pi got %0d want 20", name, phase_increment); end
      t = 0;
      while (clk_en !== 1'b1 && t < c_p + 1) begin @(negedge clock); t++; end
      if (clk_en !== 1'b1) begin
         n_cmp++; n_bad++; $display("FAIL %s_arm_timeout clk_en got %b want 1", name, clk_en);
      end
      for (int s = 0; s < n; s++) begin
         expv = bits[s] ? 8'd20 : 8'd12;
         seen = expv;
         good = 0;
         for (int c = 0; c < c_sym_clk; c++) begin
            @(negedge clock);
            if (phase_increment === expv && bit_out === bits[s] && busy === 1'b1 && data_ready === 1'b0)
               good++;
            else
               seen = phase_increment;
         end
         n_cmp++;
         if (good != c_sym_clk) begin
            n_bad++; $display("FAIL %s_sym%0d good_clocks %0d of %0d pi got %0d want %0d", name, s, good, c_sym_clk, seen, expv);
         end
      end
      @(negedge clock);
      n_cmp++;
      if (phase_increment !== 8'd20 || data_ready !== 1'b1 || busy !== 1'b0 || bit_out !== 1'b1) begin
         n_bad++; $display("FAIL %s_end pi/ready/busy/bit got %0d/%b/%b/%b want 20/1/0/1", name, phase_increment, data_ready, busy, bit_out);
      end
   endtask

   task automatic test_single;
      accept_byte(8'hA5, 1'b0);
      check_frame(8'hA5, "single_a5");
   endtask

   task automatic test_zero_frame;
      accept_byte(8'h00, 1'b0);
      check_frame(8'h00, "zero");
   endtask

   task automatic test_back_to_back;
      int bad;
      accept_byte(8'hFF, 1'b1);
      data_in = 8'h00;
      check_frame(8'hFF, "b2b_ff");
      @(posedge clock);
      @(negedge clock);
      data_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_first_idle_accept busy got %b want 1", busy); end
      check_frame(8'h00, "b2b_00");
      bad = 0;
      repeat (40) begin
         @(negedge clock);
         if (busy !== 1'b0 || phase_increment !== 8'd20) bad++;
      end
      n_cmp++;
      if (bad != 0) begin n_bad++; $display("FAIL b2b_no_extra bad_clocks got %0d want 0", bad); end
   endtask

   task automatic test_reset_mid;
      int t, bad;
      accept_byte(8'h0F, 1'b0);
      t = 0;
      while (clk_en !== 1'b1 && t < c_p + 1) begin @(negedge clock); t++; end
      repeat (3 * c_sym_clk + 5) @(negedge clock);
      n_cmp++;
      if (busy !== 1'b1 || phase_increment !== 8'd20) begin
         n_bad++; $display("FAIL mid_sym3 busy/pi got %b/%0d want 1/20", busy, phase_increment);
      end
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      n_cmp++;
      if (phase_increment !== 8'd20 || busy !== 1'b0 || data_ready !== 1'b1 || clk_en !== 1'b0 || bit_out !== 1'b1) begin
         n_bad++; $display("FAIL mid_reset pi/busy/ready/clk_en/bit got %0d/%b/%b/%b/%b want 20/0/1/0/1",
                           phase_increment, busy, data_ready, clk_en, bit_out);
      end
      reset = 1'b0;
      bad = 0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clock);
         if (clk_en !== ((k % 4) == 0) || phase_increment !== 8'd20 || busy !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin n_bad++; $display("FAIL mid_after_reset bad_clocks got %0d want 0", bad); end
   endtask

   task automatic test_edge_params;
      logic [9:0] bits;
      int n, bad;
      logic [7:0] expv;
      frame_of(8'h01, bits, n);
      bad = 0;
      repeat (5) begin
         @(negedge clock);
         if (clk_en1 !== 1'b1) bad++;
      end
      n_cmp++;
      if (bad != 0) begin n_bad++; $display("FAIL edge_clk_en low_clocks got %0d want 0", bad); end
      din1 = 8'h01; valid1 = 1'b1;
      @(posedge clock);
      @(negedge clock);
      valid1 = 1'b0;
      n_cmp++;
      if (busy1 !== 1'b1 || pi1 !== 8'd20) begin n_bad++; $display("FAIL edge_arm busy/pi got %b/%0d want 1/20", busy1, pi1); end
      for (int s = 0; s < n; s++) begin
         expv = bits[s] ? 8'd20 : 8'd12;
         @(negedge clock);
         n_cmp++;
         if (pi1 !== expv || bit1 !== bits[s]) begin
            n_bad++; $display("FAIL edge_sym%0d pi/bit got %0d/%b want %0d/%b", s, pi1, bit1, expv, bits[s]);
         end
      end
      @(negedge clock);
      n_cmp++;
      if (pi1 !== 8'd20 || ready1 !== 1'b1 || busy1 !== 1'b0) begin
         n_bad++; $display("FAIL edge_end pi/ready/busy got %0d/%b/%b want 20/1/0", pi1, ready1, busy1);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_zero_frame();
      test_back_to_back();
      test_reset_mid();
      test_edge_params();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
